// File: rtl/aes_pkg.sv
// Shared AES decryption definitions: sequencer FSM states, the
// InvMixColumns coefficient rotation and a state byte selector.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // First row of the InvMixColumns matrix; later rows are right rotations.
  localparam logic [7:0] INV_MIX_COEF [4] = '{8'd14, 8'd11, 8'd13, 8'd9};

  // Byte idx of a 128-bit state, byte 0 being the most significant.
  function automatic logic [7:0] state_byte(input logic [127:0] s,
                                            input logic [3:0]   idx);
    logic [127:0] shifted;
    shifted = s << {idx, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/inv_mixcol_col_accum.sv
// Column accumulator: folds the four ROM products of one input byte into
// the four output rows of its column. k selects the input row; k==0 starts
// a fresh column, k==3 presents the finished column with a strobe.
module inv_mixcol_col_accum
  import aes_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        valid,
  input  logic [1:0]  k,
  input  logic [7:0]  p14,
  input  logic [7:0]  p11,
  input  logic [7:0]  p13,
  input  logic [7:0]  p9,
  output logic        col_done,
  output logic [31:0] col
);

  logic [7:0] prod     [4];
  logic [7:0] contrib  [4];
  logic [7:0] acc_next [4];
  logic [7:0] acc_q    [4];

  // Order the products the same way as the coefficient table.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      prod[j] = (INV_MIX_COEF[j] == 8'd14) ? p14 :
                (INV_MIX_COEF[j] == 8'd11) ? p11 :
                (INV_MIX_COEF[j] == 8'd13) ? p13 : p9;
    end
  end

  // Row r of the output takes product P[(k - r) mod 4]; overwrite on k==0.
  // NOTE: every always_comb output is assigned on every path so no latch is inferred.
  always_comb begin
    logic [1:0] sel;
    sel = 2'd0;
    for (int r = 0; r < 4; r++) begin
      sel         = k - 2'(r);
      contrib[r]  = prod[sel];
      acc_next[r] = (k == 2'd0) ? contrib[r] : (acc_q[r] ^ contrib[r]);
    end
    col      = {acc_next[0], acc_next[1], acc_next[2], acc_next[3]};
    col_done = valid && (k == 2'd3);
  end

  // Accumulator register, advanced only when a product arrives.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < 4; r++) acc_q[r] <= '0;
    end else if (valid) begin
      for (int r = 0; r < 4; r++) acc_q[r] <= acc_next[r];
    end
  end

endmodule

// File: rtl/inv_mixcol_sequencer.sv
// InvMixColumns sequencer: streams the 16 state bytes through the shared
// GF(2^8) multiply ROMs, one per cycle, and assembles the result columns.
module inv_mixcol_sequencer
  import aes_pkg::*;
#(
  parameter int ROM_LATENCY = 1,
  parameter int NUM_BYTES   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic [127:0] State_In,
  output logic         Busy,
  output logic         Done,
  output logic [127:0] State_Out,
  output logic         Rom_Read_Enable,
  output logic [7:0]   Rom_Read_Address,
  input  logic [7:0]   Rom_Data_14,
  input  logic [7:0]   Rom_Data_11,
  input  logic [7:0]   Rom_Data_13,
  input  logic [7:0]   Rom_Data_9
);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [7:0]   drain_q;
  logic [127:0] state_in_q;

  // Delay line of (valid, byte index); stage 0 is the issue cycle itself,
  // so the last registered stage lines up with the ROM read data.
  logic         pv_q [1:ROM_LATENCY];
  logic [3:0]   pi_q [1:ROM_LATENCY];

  logic [31:0]  res_q [3];
  logic         col_done;
  logic [31:0]  col;
  logic [1:0]   col_idx;

  assign col_idx = pi_q[ROM_LATENCY][3:2];

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and ROM interface decode.
  always_comb begin
    state_d          = state_q;
    Busy             = (state_q != IDLE);
    Rom_Read_Enable  = 1'b0;
    Rom_Read_Address = 8'd0;
    unique case (state_q)
      IDLE:  if (Start) state_d = ISSUE;
      ISSUE: begin
        Rom_Read_Enable  = 1'b1;
        Rom_Read_Address = state_byte(state_in_q, cnt_q);
        if (cnt_q == 4'(NUM_BYTES - 1)) state_d = DRAIN;
      end
      DRAIN: if (drain_q == 8'(ROM_LATENCY - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input capture, byte counter and drain counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_in_q <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (Start) begin
          state_in_q <= State_In;
          cnt_q      <= '0;
        end
        ISSUE: begin
          cnt_q   <= cnt_q + 4'd1;
          drain_q <= '0;
        end
        DRAIN:   drain_q <= drain_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Product delay line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 1; s <= ROM_LATENCY; s++) begin
        pv_q[s] <= 1'b0;
        pi_q[s] <= '0;
      end
    end else begin
      pv_q[1] <= Rom_Read_Enable;
      pi_q[1] <= cnt_q;
      for (int s = 2; s <= ROM_LATENCY; s++) begin
        pv_q[s] <= pv_q[s-1];
        pi_q[s] <= pi_q[s-1];
      end
    end
  end

  inv_mixcol_col_accum u_col_accum (
    .CLK      (CLK),
    .RST      (RST),
    .valid    (pv_q[ROM_LATENCY]),
    .k        (pi_q[ROM_LATENCY][1:0]),
    .p14      (Rom_Data_14),
    .p11      (Rom_Data_11),
    .p13      (Rom_Data_13),
    .p9       (Rom_Data_9),
    .col_done (col_done),
    .col      (col)
  );

  // Column store; the last column goes straight to State_Out with Done.
  // NOTE: the small result array is reset like any register so an abort leaves no stale column.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < 3; c++) res_q[c] <= '0;
      State_Out <= '0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (col_done) begin
        unique case (col_idx)
          2'd0: res_q[0] <= col;
          2'd1: res_q[1] <= col;
          2'd2: res_q[2] <= col;
          default: begin
            State_Out <= {res_q[0], res_q[1], res_q[2], col};
            Done      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_mixcol_sequencer.sv
// Bench for inv_mixcol_sequencer: models the four registered multiply ROMs
// and compares against a matrix-form InvMixColumns reference.
module tb_inv_mixcol_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [127:0] State_In;
  logic         Busy, Done;
  logic [127:0] State_Out;
  logic         Rom_Read_Enable;
  logic [7:0]   Rom_Read_Address;
  logic [7:0]   Rom_Data_14, Rom_Data_11, Rom_Data_13, Rom_Data_9;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  inv_mixcol_sequencer dut (
    .CLK              (CLK),
    .RST              (RST),
    .Start            (Start),
    .State_In         (State_In),
    .Busy             (Busy),
    .Done             (Done),
    .State_Out        (State_Out),
    .Rom_Read_Enable  (Rom_Read_Enable),
    .Rom_Read_Address (Rom_Read_Address),
    .Rom_Data_14      (Rom_Data_14),
    .Rom_Data_11      (Rom_Data_11),
    .Rom_Data_13      (Rom_Data_13),
    .Rom_Data_9       (Rom_Data_9)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Four registered ROMs sharing one address.
  always @(posedge CLK) begin
    if (Rom_Read_Enable) begin
      Rom_Data_14 <= gmul(Rom_Read_Address, 8'd14);
      Rom_Data_11 <= gmul(Rom_Read_Address, 8'd11);
      Rom_Data_13 <= gmul(Rom_Read_Address, 8'd13);
      Rom_Data_9  <= gmul(Rom_Read_Address, 8'd9);
    end
  end

  // Reference: the InvMixColumns matrix written out row by row.
  function automatic logic [127:0] ref_inv_mix(input logic [127:0] s);
    logic [127:0] out = '0;
    logic [127:0] sh;
    logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
    for (int c = 0; c < 4; c++) begin
      sh = s << (32 * c);
      {a0, a1, a2, a3} = sh[127:96];
      b0 = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
      b1 = gmul(a0, 9)  ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
      b2 = gmul(a0, 13) ^ gmul(a1, 9)  ^ gmul(a2, 14) ^ gmul(a3, 11);
      b3 = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9)  ^ gmul(a3, 14);
      out = (out << 32) | {96'd0, b0, b1, b2, b3};
    end
    return out;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [127:0] s);
    Start    = 1'b1;
    State_In = s;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Counts cycles since acceptance until Done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!Done && cyc < 60) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b0; State_In = '0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", Done); end
    n_cmp++; if (State_Out !== '0) begin n_bad++; $display("FAIL reset_state_out got %h want 0", State_Out); end
    n_cmp++; if (Rom_Read_Enable !== 1'b0) begin n_bad++; $display("FAIL reset_rom_en got %b want 0", Rom_Read_Enable); end
    n_cmp++; if (Rom_Read_Address !== 8'd0) begin n_bad++; $display("FAIL reset_rom_addr got %h want 0", Rom_Read_Address); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0/0", Busy, Done); end
  endtask

  // Ends at the negedge of the Done cycle.
  task automatic test_known_vector();
    logic [127:0] s   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    logic [127:0] exp = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    logic [127:0] sh;
    start_op(s);
    for (int j = 0; j < 16; j++) begin
      sh = s << (8 * j);
      n_cmp++;
      if (Rom_Read_Enable !== 1'b1 || Rom_Read_Address !== sh[127:120] || Done !== 1'b0) begin
        n_bad++;
        $display("FAIL issue_byte%0d en=%b addr=%h done=%b want 1/%h/0", j, Rom_Read_Enable, Rom_Read_Address, Done, sh[127:120]);
      end
      @(posedge CLK); @(negedge CLK);
    end
    n_cmp++;
    if (Rom_Read_Enable !== 1'b0 || Rom_Read_Address !== 8'd0 || Busy !== 1'b1 || Done !== 1'b0) begin
      n_bad++;
      $display("FAIL drain en=%b addr=%h busy=%b done=%b want 0/00/1/0", Rom_Read_Enable, Rom_Read_Address, Busy, Done);
    end
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (Done !== 1'b1 || Busy !== 1'b0) begin n_bad++; $display("FAIL known_done_e17 done=%b busy=%b want 1/0", Done, Busy); end
    n_cmp++; if (State_Out !== exp) begin n_bad++; $display("FAIL known_result got %h want %h", State_Out, exp); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] prev = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    int cyc;
    start_op('0);
    n_cmp++; if (Busy !== 1'b1 || Done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept busy=%b done=%b want 1/0", Busy, Done); end
    n_cmp++; if (State_Out !== prev) begin n_bad++; $display("FAIL b2b_hold got %h want %h", State_Out, prev); end
    wait_done(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL b2b_latency got %0d want 17", cyc); end
    n_cmp++; if (State_Out !== '0) begin n_bad++; $display("FAIL b2b_result got %h want 0", State_Out); end
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_width got %b want 0", Done); end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] s = rand_state();
    logic [127:0] exp = ref_inv_mix(s);
    int dones = 0, first = -1;
    start_op(s);
    for (int n = 0; n < 40; n++) begin
      if (Done) begin
        dones++;
        if (first < 0) first = n;
        n_cmp++; if (State_Out !== exp) begin n_bad++; $display("FAIL busy_start_result got %h want %h", State_Out, exp); end
      end
      Start    = (n == 4);
      State_In = (n == 4) ? rand_state() : s;
      @(posedge CLK); @(negedge CLK);
    end
    Start = 1'b0;
    n_cmp++; if (dones != 1 || first != 17) begin n_bad++; $display("FAIL busy_start_ignored dones=%0d at=%0d want 1 at 17", dones, first); end
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] s = rand_state();
    int cyc;
    start_op(s);
    repeat (8) begin @(posedge CLK); @(negedge CLK); end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if (Busy !== 1'b0 || Done !== 1'b0 || State_Out !== '0 || Rom_Read_Enable !== 1'b0 || Rom_Read_Address !== 8'd0) begin
      n_bad++;
      $display("FAIL async_reset busy=%b done=%b out=%h en=%b addr=%h want all 0", Busy, Done, State_Out, Rom_Read_Enable, Rom_Read_Address);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (n == 3) RST = 1'b0;
      n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done cycle %0d got %b want 0", n, Done); end
    end
    s = rand_state();
    start_op(s);
    wait_done(cyc);
    n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL post_reset_latency got %0d want 17", cyc); end
    n_cmp++; if (State_Out !== ref_inv_mix(s)) begin n_bad++; $display("FAIL post_reset_result got %h want %h", State_Out, ref_inv_mix(s)); end
    @(negedge CLK);
  endtask

  task automatic test_start_held();
    logic [127:0] s = rand_state();
    logic [127:0] exp = ref_inv_mix(s);
    int pos [$];
    int cyc;
    Start = 1'b1; State_In = s;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); @(negedge CLK);
      if (Done) begin
        pos.push_back(n);
        n_cmp++;
        if (Busy !== 1'b0 || State_Out !== exp) begin
          n_bad++;
          $display("FAIL held_result busy=%b got %h want 0/%h", Busy, State_Out, exp);
        end
      end
    end
    Start = 1'b0;
    n_cmp++;
    if (pos.size() != 2 || pos[0] != 17 || pos[1] != 35) begin
      n_bad++;
      $display("FAIL held_period count=%0d want done at 17 and 35", pos.size());
    end
    wait_done(cyc);
    n_cmp++; if (Done !== 1'b1 || State_Out !== exp) begin n_bad++; $display("FAIL held_third got done=%b out=%h want 1/%h", Done, State_Out, exp); end
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [127:0] s;
    int cyc;
    for (int t = 0; t < 8; t++) begin
      s = rand_state();
      start_op(s);
      wait_done(cyc);
      n_cmp++; if (cyc != 17) begin n_bad++; $display("FAIL rand%0d_latency got %0d want 17", t, cyc); end
      n_cmp++; if (State_Out !== ref_inv_mix(s)) begin n_bad++; $display("FAIL rand%0d_result got %h want %h", t, State_Out, ref_inv_mix(s)); end
      @(negedge CLK);
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_op();
    test_start_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_mixcol_sequencer.md
Name: inv_mixcol_sequencer

Overview:
- Sequences the registered GF(2^8) multiply ROMs (x9, x11, x13, x14; one shared read address, 1-cycle registered read) to compute AES InvMixColumns over a full 128-bit state.
- Issues one state byte per cycle to all four ROMs and XOR-accumulates the returned products into output columns.
- Sits between AddRoundKey and InvShiftRows in the decryption round datapath, driven by the round controller over a Start/Busy/Done handshake.

Parameters:
- ROM_LATENCY, 1, cycles from ROM address sample to valid Read_Data; sets the product delay line and drain length.
- NUM_BYTES, 16, state bytes per operation; fixed at 16 for AES, kept only for loop bounds.

Ports:
- CLK  in  1  single clock; every register rises on posedge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  request pulse; accepted only in IDLE.
- State_In  in  128  input state; byte 0 = [127:120], column c = bytes 4c..4c+3, row = byte%4.
- Busy  out  1  high whenever FSM != IDLE.
- Done  out  1  one-cycle pulse when State_Out is updated.
- State_Out  out  128  InvMixColumns result; holds until the next Done.
- Rom_Read_Enable  out  1  read enable to all four ROMs.
- Rom_Read_Address  out  8  byte sent to all four ROMs.
- Rom_Data_14  in  8  x14 product.
- Rom_Data_11  in  8  x11 product.
- Rom_Data_13  in  8  x13 product.
- Rom_Data_9  in  8  x9 product.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - Busy = 0, Done = 0, State_Out = 0.
  - Rom_Read_Enable = 0, Rom_Read_Address = 0.
  - Captured input, accumulator, byte counter and valid delay line all cleared.
- Reset mid-operation aborts immediately; State_Out returns to 0 and no Done is issued.
- FSM states:
  - IDLE: Start=1 at edge E0 captures State_In, clears counter i=0, moves to ISSUE.
  - ISSUE, 16 cycles: Rom_Read_Enable=1, Rom_Read_Address = captured byte i (combinational from counter); i increments each cycle. After i=15, go to DRAIN.
  - DRAIN, ROM_LATENCY cycles: Rom_Read_Enable=0, Rom_Read_Address=0. On the last drain cycle, go to IDLE.
- Product delay line carries (valid, i) ROM_LATENCY+1 stages. The product for byte i is consumed at edge E(i+1+ROM_LATENCY).
- Accumulation:
  - Let k = i%4, c = i/4, P = [p14, p11, p13, p9].
  - For each r in 0..3: contribution to output row r is P[(k−r) mod 4]. This gives coefficient rows {14,11,13,9}, {9,14,11,13}, {13,9,14,11}, {11,13,9,14}.
  - k==0: acc = contribution (overwrite). k>0: acc ^= contribution.
  - k==3: write the completed column (acc ^ final contribution) into result column c.
- Completion: at edge E(16+ROM_LATENCY), i.e. E17 by default, the last column is written, State_Out is loaded from the full result, and Done=1 for exactly one cycle.
- Busy is high from E0 through E(16+ROM_LATENCY); Busy=0 in the cycle Done=1.
- Start while Busy is ignored, with no queueing. Start in the same cycle Done is high is accepted (FSM is already IDLE).
- All arithmetic is XOR on 8-bit bytes; no carries, no widening.

Decomposition:
- Shared package (aes_pkg):
  - FSM state enum: IDLE, ISSUE, DRAIN.
  - INV_MIX_COEF rotation table {14,11,13,9}.
  - byte-select function (state, index) → byte.
- One natural sub-module: inv_mixcol_col_accum.
  - Function: 4-byte accumulator with overwrite-on-k0 and column-complete strobe on k3.
  - Inputs: four products and k.

Test Plan:
- Bench instantiates the four ROMs plus the sequencer.
- Reset then idle: Rom_Read_Enable=0, Busy=0, Done=0, State_Out=0.
- State_In = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, pulse Start at E0:
  - Rom_Read_Address = 8e,4d,a1,bc,9f,... on E1..E16.
  - Done only at E17, State_Out = db135345_f20a225c_01010101_c6c6c6c6.
- Back-to-back: assert Start again in the Done cycle with State_In = all-zero:
  - accepted immediately; second Done 17 cycles later; State_Out = 0.
- Start pulsed at E5 while Busy:
  - ignored; a single Done at E17 with the first result.
- RST at E9 mid-operation:
  - all outputs 0 asynchronously; no Done.
  - Start after release: Done 17 cycles later with the correct result.
- Start held high for 40 cycles with a constant State_In:
  - Done pulses every 18 cycles (17 busy + 1 idle-accept); result identical each time.
